// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry fed back
// through a flop. {cout,sum} = a + b + cin after WIDTH RUN cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             last;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (c_ff),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last = (cnt == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only sampled on the accepting edge; start elsewhere is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_ff <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c_ff <= cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= {fa_sum, s_sh[WIDTH-1:1]};
          c_ff <= fa_carry;
          if (last) begin
            cnt  <= '0;
            sum  <= {fa_sum, s_sh[WIDTH-1:1]};
            cout <= fa_carry;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed cases plus an
// exhaustive WIDTH=2 sweep on a second instance.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;

  logic       start2, cin2;
  logic [1:0] a2, b2, sum2;
  logic       busy2, done2, cout2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] q[$];
  logic [2:0] q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("result8", {cout, sum}, q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else chk("result2", {cout2, sum2}, q2.pop_front());
    end
  end

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (busy !== val && n < 50) begin n++; @(negedge clk); end
    chk(name, busy, val);
  endtask

  task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [8:0] expv, input string name);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk({name, "_busy_cycles"}, n, 8);
    chk({name, "_done"}, done, 1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 0);
  endtask

  task automatic do_add2(input logic [1:0] av, input logic [1:0] bv, input logic cv,
                         input logic [2:0] expv);
    int n = 0;
    @(negedge clk);
    a2 = av; b2 = bv; cin2 = cv; start2 = 1'b1;
    q2.push_back(expv);
    @(negedge clk);
    start2 = 1'b0;
    while (busy2 && n < 20) begin n++; @(negedge clk); end
    chk("w2_busy_cycles", n, 2);
    chk("w2_done", done2, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum_cout", {cout, sum}, 9'h000);
    rst = 1'b0;

    do_add(8'h5A, 8'h3C, 1'b0, 9'h096, "basic");
    do_add(8'hFF, 8'h01, 1'b0, 9'h100, "ripple");
    do_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, "max");
    do_add(8'h00, 8'h00, 1'b1, 9'h001, "min");

    // start during RUN is ignored and operand changes have no effect
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    q.push_back(9'h030);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_busy", busy, 1);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    wait_busy(0, "ign_finish");
    chk("ign_done", done, 1);
    repeat (6) @(negedge clk);
    chk("ign_hold", {cout, sum}, 9'h030);
    chk("ign_idle", busy, 0);

    // reset in cycle 4 of RUN
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_sum_cout", {cout, sum}, 9'h000);
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid_no_restart", {busy, done}, 2'b00);
    do_add(8'h03, 8'h04, 1'b0, 9'h007, "after_rst");

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    q.push_back(9'h003);
    wait_busy(1, "b2b_first_accept");
    t1 = cyc;
    a = 8'h80; b = 8'h80;
    q.push_back(9'h100);
    wait_busy(0, "b2b_first_end");
    wait_busy(1, "b2b_second_accept");
    t2 = cyc;
    start = 1'b0;
    chk("b2b_accept_gap", t2 - t1, 10);
    wait_busy(0, "b2b_second_end");
    chk("b2b_done", done, 1);
    @(negedge clk);

    // exhaustive WIDTH=2
    for (int i = 0; i < 32; i++) begin
      logic [1:0] av, bv;
      logic       cv;
      logic [2:0] ev;
      av = i[4:3]; bv = i[2:1]; cv = i[0];
      ev = {1'b0, av} + {1'b0, bv} + {2'b00, cv};
      do_add2(av, bv, cv, ev);
    end

    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 50) begin n++; @(negedge clk); end
    chk("drain_q8", q.size(), 0);
    chk("drain_q2", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
